// File: rtl/ring_osc_meter.sv
// ---------------------------------------------------------------------------
// ring_osc_meter
//
// Builds NCH AND-gated ring oscillators and counts the rising edges of one of
// them over a programmable window of clk cycles. Channel k has
// BASE_N + STEP_N*k inverters. Only the latched channel is enabled, and only
// while a measurement is settling or counting. The ring tap is brought into
// the clk domain through a 3-flop synchroniser, and each 0->1 step between
// flops 2 and 3 counts as one edge.
//
// Optional feature: define RO_PRESCALE_EN to place a divide-by-16 ripple
// counter, clocked by the ring tap, in front of the synchroniser. The result
// is then ring edges / 16. Without it, the tap feeds the synchroniser directly
// and the ring period must exceed two clk periods.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   start    measurement request, sampled on the clk rising edge
//   ch_sel   channel to measure, latched when a start is accepted
//   win_len  window length in clk cycles, latched when a start is accepted
//   busy     measurement in progress (SETTLE, COUNT, DONE)
//   done     one-cycle completion pulse
//   count    edges counted in the last window (saturating)
//   ovf      count saturated during the last window
//   err      last request selected a channel >= NCH
//   run      the selected ring is enabled (SETTLE, COUNT)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ring_osc_meter #(
   parameter int NCH    = 4,
   parameter int BASE_N = 5,
   parameter int STEP_N = 2,
   parameter int WIN_W  = 16,
   parameter int CNT_W  = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ch_sel,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             err,
   output logic             run
);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             req_bad;
   logic [3:0]       ch_lat;
   logic [WIN_W-1:0] win_lat;
   logic [2:0]       settle_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_cnt_nxt;
   logic [2:0]       sync;
   logic             rise;
   logic             tap;
   logic             sync_in;
   logic [NCH-1:0]   ring_tap;
   logic [NCH-1:0]   ring_en;

   // ------------------------------------------------------------------------
   // Ring oscillators. Gate delays exist only in simulation so that the loop
   // oscillates with a period of 2*(N+1) time units. Synthesis sees plain
   // gates, and keep stops the loop from being optimised away.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      localparam int N = BASE_N + STEP_N * k;
      (* keep = "true" *) logic         and_out;
      (* keep = "true" *) logic [N-1:0] inv;

      assign ring_en[k] = run & (ch_lat == 4'(k));
`ifndef SYNTHESIS
      assign #1 and_out = ring_en[k] & inv[N-1];
      assign #1 inv[0]  = ~and_out;
      for (genvar i = 1; i < N; i++) begin : g_inv
         assign #1 inv[i] = ~inv[i-1];
      end
`else
      assign and_out = ring_en[k] & inv[N-1];
      assign inv[0]  = ~and_out;
      for (genvar i = 1; i < N; i++) begin : g_inv
         assign inv[i] = ~inv[i-1];
      end
`endif
      assign ring_tap[k] = and_out;
   end

   // Disabled rings sit with their AND output at 0, so OR-ing the taps
   // yields the running ring without a channel mux.
   assign tap = |ring_tap;

`ifdef RO_PRESCALE_EN
   logic [3:0] pre;
   logic       pre_clr_n;

   // Held cleared while the rings are stopped, so every measurement starts
   // the divider from zero.
   assign pre_clr_n = rst_n & run;

   always_ff @(posedge tap or negedge pre_clr_n) begin
      if (!pre_clr_n) pre <= 4'd0;
      else            pre <= pre + 4'd1;
   end

   assign sync_in = pre[3];
`else
   assign sync_in = tap;
`endif

   // ------------------------------------------------------------------------
   // Synchroniser into clk and edge detect between flops 2 and 3
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 3'b000;
      else        sync <= {sync[1:0], sync_in};
   end

   assign rise = sync[1] & ~sync[2];

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   assign req_bad = ({1'b0, ch_sel} >= 5'(NCH));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = req_bad ? DONE : SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == 3'd7)
               state_nxt = (win_lat == '0) ? DONE : COUNT;
         end
         COUNT: begin
            if (win_cnt == win_lat) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter value including this cycle's edge, saturating at all-ones.
   always_comb begin
      edge_cnt_nxt = edge_cnt;
      if (rise && !(&edge_cnt)) edge_cnt_nxt = edge_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run   <= 1'b0;
         count <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= (state_nxt == SETTLE) || (state_nxt == COUNT);
         if (accept && !req_bad) err <= 1'b0;
         // Results are loaded on entry to DONE so they are valid while the
         // done pulse is high.
         if (state_nxt == DONE && state != DONE) begin
            if (state == COUNT) begin
               count <= edge_cnt_nxt;
               ovf   <= &edge_cnt_nxt;
            end else begin
               count <= '0;
               ovf   <= 1'b0;
            end
            if (state == IDLE) err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Request latches, settle/window timers and edge counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         ch_lat  <= ch_sel;
         win_lat <= win_len;
      end
      settle_cnt <= (state == SETTLE) ? settle_cnt + 3'd1 : 3'd0;
      if (state_nxt == COUNT && state != COUNT) begin
         edge_cnt <= '0;
         win_cnt  <= WIN_W'(1);
      end else if (state == COUNT) begin
         edge_cnt <= edge_cnt_nxt;
         win_cnt  <= win_cnt + WIN_W'(1);
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
